seq_array_divider: RTL

- Sequential restoring divider; inverse of the array multiplier (c = a*b). Recovers the 7-bit factor a and a 6-bit remainder r from a 13-bit product-width dividend c and a 6-bit divisor b.
- Supports the same t mode select: t=1 two's-complement signed, t=0 unsigned.
- Produces one quotient bit per clock over a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath.

---
 rtl/arith_pkg.sv | 18 +
 rtl/twos_mag.sv | 17 +
 rtl/seq_array_divider.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic datapath definitions: operand widths, divider states, iteration count.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package arith_pkg;

   localparam int A_W   = 7;            // quotient width, matches multiplier operand a
   localparam int B_W   = 6;            // divisor / remainder width, matches multiplier operand b
   localparam int C_W   = A_W + B_W;    // dividend (product) width
   localparam int ITER  = C_W;          // one quotient bit per dividend bit
   localparam int CNT_W = $clog2(ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/twos_mag.sv
// Conditional two's-complement negate: val_o = neg_i ? -val_i : val_i.
// Latency: combinational.
// Backpressure: none.
// Ports: neg_i  negate select
//        val_i  W-bit operand
//        val_o  W-bit result (the most negative input maps to itself, read as unsigned magnitude)
module twos_mag #(
   parameter int W = 8
) (
   input  logic         neg_i,
   input  logic [W-1:0] val_i,
   output logic [W-1:0] val_o
);

   assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/seq_array_divider.sv
// Sequential restoring divider, c / b -> quotient a, remainder r; signed (t=1) or unsigned (t=0).
// Latency: done 15 cycles after the start cycle (2 cycles for divide by zero); one quotient bit per clock.
// Backpressure: start is accepted only when idle and not in the done cycle; otherwise ignored.
// Ports: clk, rst (async, active-high)
//        start, t, c, b      request, mode and operands, captured together
//        busy, done          operation in progress / single-cycle completion pulse
//        a, r                quotient / remainder, held until the next completion
//        div_zero, overflow  status flags, cleared on the next accepted start
module seq_array_divider
   import arith_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           t,
   input  logic [C_W-1:0] c,
   input  logic [B_W-1:0] b,
   output logic           busy,
   output logic           done,
   output logic [A_W-1:0] a,
   output logic [B_W-1:0] r,
   output logic           div_zero,
   output logic           overflow
);

   state_e           state_q;
   logic [C_W-1:0]   dvd_q;      // dividend bits shift out the top, quotient bits shift in at the bottom
   logic [B_W-1:0]   rem_q;      // partial remainder, always < |b| so B_W bits suffice between steps
   logic [B_W-1:0]   bmag_q;
   logic [CNT_W-1:0] cnt_q;
   logic             t_q;
   logic             qsign_q;
   logic             rsign_q;
   logic             dz_q;

   logic [C_W-1:0]   c_mag;
   logic [B_W-1:0]   b_mag;
   logic [A_W-1:0]   a_fix;
   logic [B_W-1:0]   r_fix;

   logic [B_W:0]     rem_sh;
   logic             fits;
   logic [B_W-1:0]   rem_d;
   logic [C_W-1:0]   dvd_d;
   logic [C_W-1:0]   qmax;
   logic             ovf_fix;

   // Operand magnitudes on capture.
   twos_mag #(.W(C_W)) u_c_mag (.neg_i(t & c[C_W-1]), .val_i(c), .val_o(c_mag));
   twos_mag #(.W(B_W)) u_b_mag (.neg_i(t & b[B_W-1]), .val_i(b), .val_o(b_mag));

   // Sign restoration of the magnitude results.
   twos_mag #(.W(A_W)) u_a_sgn (.neg_i(qsign_q), .val_i(dvd_q[A_W-1:0]), .val_o(a_fix));
   twos_mag #(.W(B_W)) u_r_sgn (.neg_i(rsign_q), .val_i(rem_q), .val_o(r_fix));

   // One restoring step: shift, trial subtract, keep difference only if it did not borrow.
   always_comb begin
      rem_sh = {rem_q, dvd_q[C_W-1]};
      fits   = (rem_sh >= {1'b0, bmag_q});
      rem_d  = fits ? B_W'(rem_sh - {1'b0, bmag_q}) : rem_sh[B_W-1:0];
      dvd_d  = {dvd_q[C_W-2:0], fits};
   end

   // Largest representable quotient magnitude: negative results reach one further (-64).
   always_comb begin
      qmax = C_W'(127);
      if (t_q) begin
         qmax = qsign_q ? C_W'(64) : C_W'(63);
      end
      ovf_fix = (dvd_q > qmax);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         a        <= '0;
         r        <= '0;
         div_zero <= 1'b0;
         overflow <= 1'b0;
         dvd_q    <= '0;
         rem_q    <= '0;
         bmag_q   <= '0;
         cnt_q    <= '0;
         t_q      <= 1'b0;
         qsign_q  <= 1'b0;
         rsign_q  <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               // done is still high in the first idle cycle; starts there are dropped.
               if (start && !done) begin
                  busy     <= 1'b1;
                  div_zero <= 1'b0;
                  overflow <= 1'b0;
                  t_q      <= t;
                  qsign_q  <= t & (c[C_W-1] ^ b[B_W-1]);
                  rsign_q  <= t & c[C_W-1];
                  dvd_q    <= c_mag;
                  bmag_q   <= b_mag;
                  rem_q    <= '0;
                  cnt_q    <= CNT_W'(ITER - 1);
                  if (b == '0) begin
                     dz_q    <= 1'b1;
                     state_q <= FIX;
                  end else begin
                     dz_q    <= 1'b0;
                     state_q <= DIV;
                  end
               end
            end
            DIV: begin
               dvd_q <= dvd_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               state_q  <= IDLE;
               busy     <= 1'b0;
               done     <= 1'b1;
               div_zero <= dz_q;
               if (dz_q) begin
                  a        <= '1;
                  r        <= '0;
                  overflow <= 1'b0;
               end else if (ovf_fix) begin
                  a        <= '0;
                  r        <= '0;
                  overflow <= 1'b1;
               end else begin
                  a        <= a_fix;
                  r        <= r_fix;
                  overflow <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
